// File: rtl/noc_router_if.sv
// Link, routing-table and status signals of one noc_router node.
// Handshake: an upstream sender may launch a start bit on rx_data[p] only in a cycle after it
// sampled rx_busy[p]==0; tx_data[o] starts a frame only in a cycle after tx_busy[o] was sampled 0.
// Frame bits already in flight are never stalled in either direction.
interface noc_router_if #(
    parameter int SIZE     = 4,
    parameter int BITS_DIR = 3
);
    logic [4:0]          rx_busy;
    logic [4:0]          rx_data;
    logic [4:0]          tx_busy;
    logic [4:0]          tx_data;
    logic [SIZE-1:0]     table_addr;
    logic [BITS_DIR-1:0] table_data;
    logic [2:0]          activity_level;
    logic [9:0]          dbg_in_state;
    logic [4:0]          dbg_out_send;

    modport slave (
        input  rx_data, tx_busy, table_data,
        output rx_busy, tx_data, table_addr, activity_level, dbg_in_state, dbg_out_send
    );

    modport master (
        output rx_data, tx_busy, table_data,
        input  rx_busy, tx_data, table_addr, activity_level, dbg_in_state, dbg_out_send
    );
endinterface

// File: rtl/noc_router.sv
// 5-port store-and-forward mesh router: serial receive, one shared routing-table lookup
// per cycle, per-output round-robin grant and serial transmit.
module noc_router #(
    parameter int ID       = 0,
    parameter int SIZE     = 4,
    parameter int BITS_DIR = 3,
    parameter int PAYLOAD  = 8
) (
    input  logic        clk,
    input  logic        reset,
    noc_router_if.slave nif
);
    localparam int W  = SIZE + PAYLOAD;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IN_IDLE, IN_RECV, IN_FULL, IN_ROUTED} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

    in_state_t     in_state  [5];
    in_state_t     in_next   [5];
    logic [CW-1:0] in_cnt    [5];
    logic [W-1:0]  in_buf    [5];
    logic [2:0]    in_dir    [5];
    logic [4:0]    handoff;

    out_state_t    out_state [5];
    out_state_t    out_next  [5];
    logic [CW-1:0] out_cnt   [5];
    logic [W:0]    out_sr    [5];
    logic [2:0]    gr_ptr    [5];
    logic [4:0]    out_req   [5];
    logic [4:0]    out_free;
    logic [4:0]    gr_valid;
    logic [2:0]    gr_port   [5];

    logic [2:0]    lk_ptr;
    logic          lk_valid;
    logic [2:0]    lk_port;
    logic [SIZE-1:0] lk_dest;
    logic          lk_ok;
    logic [2:0]    lk_dir;
    logic [4:0]    full_req;
    logic [2:0]    act_next;

    // Nearest requester after ptr wins; returns {hit, index}.
    function automatic logic [3:0] rr_pick(input logic [2:0] ptr, input logic [4:0] req);
        logic [3:0] pick;
        pick = 4'b0;
        for (int k = 5; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % 5]) pick = {1'b1, 3'((int'(ptr) + k) % 5)};
        end
        return pick;
    endfunction

    always_comb begin
        full_req = '0;
        for (int p = 0; p < 5; p++) full_req[p] = (in_state[p] == IN_FULL);
        {lk_valid, lk_port} = rr_pick(lk_ptr, full_req);
        lk_dest = lk_valid ? in_buf[lk_port][SIZE-1:0] : '0;
        nif.table_addr = lk_dest;
        // A packet addressed to this node always leaves through the local port.
        if (lk_dest == SIZE'(ID)) begin
            lk_ok  = 1'b1;
            lk_dir = 3'd0;
        end else begin
            lk_ok  = 32'(nif.table_data) < 32'd5;
            lk_dir = nif.table_data[2:0];
        end
    end

    // A serializer on its final bit counts as free so frames can go out back to back.
    always_comb begin
        gr_valid = '0;
        handoff  = '0;
        out_free = '0;
        for (int o = 0; o < 5; o++) begin
            out_req[o] = '0;
            gr_port[o] = '0;
            for (int p = 0; p < 5; p++)
                out_req[o][p] = (in_state[p] == IN_ROUTED) && (in_dir[p] == 3'(o));
            out_free[o] = (out_state[o] == OUT_IDLE) || (out_cnt[o] == CW'(W));
            if (out_free[o] && !nif.tx_busy[o])
                {gr_valid[o], gr_port[o]} = rr_pick(gr_ptr[o], out_req[o]);
        end
        for (int o = 0; o < 5; o++)
            if (gr_valid[o]) handoff[gr_port[o]] = 1'b1;
    end

    always_comb begin
        act_next = '0;
        for (int p = 0; p < 5; p++) begin
            in_next[p] = in_state[p];
            case (in_state[p])
                IN_IDLE:   if (nif.rx_data[p]) in_next[p] = IN_RECV;
                IN_RECV:   if (in_cnt[p] == CW'(W - 1)) in_next[p] = IN_FULL;
                IN_FULL:   if (lk_valid && lk_port == 3'(p)) in_next[p] = lk_ok ? IN_ROUTED : IN_IDLE;
                IN_ROUTED: if (handoff[p]) in_next[p] = IN_IDLE;
                default:   in_next[p] = IN_IDLE;
            endcase
        end
        for (int o = 0; o < 5; o++) begin
            out_next[o] = out_state[o];
            if (out_state[o] == OUT_IDLE) begin
                if (gr_valid[o]) out_next[o] = OUT_SEND;
            end else if (out_cnt[o] == CW'(W)) begin
                out_next[o] = gr_valid[o] ? OUT_SEND : OUT_IDLE;
            end
            act_next = act_next + {2'b0, out_next[o] == OUT_SEND};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_ptr             <= '0;
            nif.activity_level <= '0;
            for (int p = 0; p < 5; p++) begin
                in_state[p] <= IN_IDLE;
                in_cnt[p]   <= '0;
                in_buf[p]   <= '0;
                in_dir[p]   <= '0;
            end
            for (int o = 0; o < 5; o++) begin
                out_state[o] <= OUT_IDLE;
                out_cnt[o]   <= '0;
                out_sr[o]    <= '0;
                gr_ptr[o]    <= '0;
            end
        end else begin
            if (lk_valid) lk_ptr <= lk_port;
            nif.activity_level <= act_next;
            for (int p = 0; p < 5; p++) begin
                in_state[p] <= in_next[p];
                if (in_state[p] == IN_IDLE) in_cnt[p] <= '0;
                if (in_state[p] == IN_RECV) begin
                    in_buf[p] <= {nif.rx_data[p], in_buf[p][W-1:1]};
                    in_cnt[p] <= in_cnt[p] + CW'(1);
                end
                if (in_state[p] == IN_FULL && lk_valid && lk_port == 3'(p)) in_dir[p] <= lk_dir;
            end
            for (int o = 0; o < 5; o++) begin
                out_state[o] <= out_next[o];
                if (gr_valid[o]) begin
                    out_sr[o]  <= {in_buf[gr_port[o]], 1'b1};
                    out_cnt[o] <= '0;
                    gr_ptr[o]  <= gr_port[o];
                end else if (out_state[o] == OUT_SEND) begin
                    out_sr[o]  <= out_sr[o] >> 1;
                    out_cnt[o] <= out_cnt[o] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        nif.rx_busy      = '0;
        nif.tx_data      = '0;
        nif.dbg_in_state = '0;
        nif.dbg_out_send = '0;
        for (int p = 0; p < 5; p++) begin
            nif.rx_busy[p]              = (in_state[p] != IN_IDLE);
            nif.dbg_in_state[2*p +: 2]  = in_state[p];
            nif.tx_data[p]              = (out_state[p] == OUT_SEND) && out_sr[p][0];
            nif.dbg_out_send[p]         = (out_state[p] == OUT_SEND);
        end
    end
endmodule

// File: tb/tb_noc_router.sv
// Directed bench for noc_router as node 5: reset, single hop, local delivery, contention,
// back-pressure and invalid routes, checked by a per-output frame monitor against expected queues.
module tb_noc_router;
    localparam int W    = 12;
    localparam int NODE = 5;

    logic         clk = 1'b0;
    logic         reset;
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [2:0]   route_tab [16];
    logic [W-1:0] exp_q   [5][$];
    int           exp_t_q [5][$];

    noc_router_if #(.SIZE(4), .BITS_DIR(3)) nif ();

    noc_router #(.ID(NODE), .SIZE(4), .BITS_DIR(3), .PAYLOAD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .nif   (nif)
    );

    // Clock, cycle counter and the external routing table.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign nif.table_data = route_tab[nif.table_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        nif.rx_data = '0;
        nif.tx_busy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Frame on the wire: start bit, dest LSB first, payload LSB first.
    task automatic drive_pkt(input int port, input logic [3:0] dest, input logic [7:0] pay,
                             output int last_cyc);
        logic [12:0] f;
        f = {pay, dest, 1'b1};
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            nif.rx_data[port] = f[i];
        end
        last_cyc = cyc;
        @(posedge clk);
        #1;
        nif.rx_data[port] = 1'b0;
    endtask

    task automatic expect_pkt(input int port, input logic [3:0] dest, input logic [7:0] pay,
                              input int start_cyc);
        exp_q[port].push_back({pay, dest});
        exp_t_q[port].push_back(start_cyc);
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        for (int o = 0; o < 5; o++)
            check($sformatf("pending_pkts_p%0d", o), exp_q[o].size(), 0);
    endtask

    // Monitor: deserializes each output frame and compares it with the head of that port's queue.
    int           mon_cnt [5];
    int           mon_t0  [5];
    logic [W-1:0] mon_sr  [5];
    logic [W-1:0] mon_e;
    int           mon_et;

    always @(negedge clk) begin
        for (int o = 0; o < 5; o++) begin
            if (!reset) begin
                mon_cnt[o] = 0;
            end else if (mon_cnt[o] == 0) begin
                if (nif.tx_data[o]) begin
                    mon_cnt[o] = 1;
                    mon_t0[o]  = cyc;
                end
            end else begin
                mon_sr[o] = {nif.tx_data[o], mon_sr[o][W-1:1]};
                mon_cnt[o]++;
                if (mon_cnt[o] == W + 1) begin
                    mon_cnt[o] = 0;
                    if (exp_q[o].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_pkt_p%0d: got %0h expected none", o, mon_sr[o]);
                    end else begin
                        mon_e  = exp_q[o].pop_front();
                        mon_et = exp_t_q[o].pop_front();
                        check($sformatf("pkt_data_p%0d", o), mon_sr[o], mon_e);
                        check($sformatf("pkt_start_cycle_p%0d", o), mon_t0[o], mon_et);
                    end
                end
            end
        end
    end

    initial begin
        int t, t1, t3, r, bad;
        for (int a = 0; a < 16; a++) route_tab[a] = 3'd0;
        reset       = 1'b0;
        nif.rx_data = '0;
        nif.tx_busy = '0;

        // Reset state.
        @(negedge clk);
        check("rst_rx_busy", nif.rx_busy, 0);
        check("rst_tx_data", nif.tx_data, 0);
        check("rst_table_addr", nif.table_addr, 0);
        check("rst_activity", nif.activity_level, 0);

        // Reset mid-reception on port 2: packet must be lost.
        route_tab[6] = 3'd2;
        apply_reset();
        begin
            logic [12:0] f;
            f = {8'h5A, 4'd6, 1'b1};
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                nif.rx_data[2] = f[i];
            end
        end
        @(negedge clk);
        check("rx_busy_p2_recv", nif.rx_busy[2], 1);
        @(posedge clk);
        #2;
        reset          = 1'b0;
        nif.rx_data[2] = 1'b0;
        #1;
        check("midrst_rx_busy", nif.rx_busy, 0);
        check("midrst_tx_data", nif.tx_data, 0);
        check("midrst_table_addr", nif.table_addr, 0);
        check("midrst_activity", nif.activity_level, 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (nif.tx_data !== 5'b0 || nif.rx_busy !== 5'b0) bad++;
        end
        check("idle_after_reset_bad_cycles", bad, 0);
        drain(2);

        // Single hop: dest 6 -> east (2), payload 0x5A from local port.
        apply_reset();
        @(negedge clk);
        check("rx_busy_p0_before", nif.rx_busy[0], 0);
        fork
            drive_pkt(0, 4'd6, 8'h5A, t);
            begin
                repeat (4) @(negedge clk);
                check("rx_busy_p0_recv", nif.rx_busy[0], 1);
            end
        join
        expect_pkt(2, 4'd6, 8'h5A, t + 3);
        @(negedge clk);
        check("rx_busy_p0_full", nif.rx_busy[0], 1);
        @(negedge clk);
        check("rx_busy_p0_handoff", nif.rx_busy[0], 1);
        @(negedge clk);
        check("rx_busy_p0_after_handoff", nif.rx_busy[0], 0);
        check("hop_activity", nif.activity_level, 1);
        check("hop_tx_start_bit", nif.tx_data, 5'b00100);
        drain(20);
        check("hop_activity_done", nif.activity_level, 0);

        // Local delivery: dest == ID ignores the table entry (3).
        route_tab[5] = 3'd3;
        apply_reset();
        drive_pkt(0, 4'd5, 8'hC3, t);
        expect_pkt(0, 4'd5, 8'hC3, t + 3);
        drain(20);

        // Contention: ports 1 and 3 finish together, both to east.
        route_tab[9] = 3'd2;
        apply_reset();
        fork
            drive_pkt(1, 4'd9, 8'h11, t1);
            drive_pkt(3, 4'd9, 8'h33, t3);
        join
        expect_pkt(2, 4'd9, 8'h11, t1 + 3);
        expect_pkt(2, 4'd9, 8'h33, t1 + 16);
        repeat (2) @(negedge clk);
        bad = 0;
        repeat (26) begin
            @(negedge clk);
            if (nif.activity_level !== 3'd1) bad++;
        end
        check("contention_activity_bad_cycles", bad, 0);
        drain(10);

        // Back-pressure on west (4) for 20 cycles after the packet is routed.
        route_tab[12] = 3'd4;
        apply_reset();
        nif.tx_busy[4] = 1'b1;
        drive_pkt(0, 4'd12, 8'hA5, t);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (nif.tx_data[4] !== 1'b0 || nif.rx_busy[0] !== 1'b1) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        @(posedge clk);
        #1;
        nif.tx_busy[4] = 1'b0;
        r = cyc;
        expect_pkt(4, 4'd12, 8'hA5, r + 1);
        @(negedge clk);
        check("bp_rx_busy_at_release", nif.rx_busy[0], 1);
        @(negedge clk);
        check("bp_rx_busy_after_handoff", nif.rx_busy[0], 0);
        drain(20);

        // Invalid routes (7 and 5) are dropped; a valid packet then U-turns on port 1.
        route_tab[7]  = 3'd7;
        route_tab[10] = 3'd5;
        route_tab[8]  = 3'd1;
        apply_reset();
        drive_pkt(1, 4'd7, 8'h3C, t);
        @(negedge clk);
        check("inv7_rx_busy_full", nif.rx_busy[1], 1);
        @(negedge clk);
        check("inv7_rx_busy_dropped", nif.rx_busy[1], 0);
        drive_pkt(3, 4'd10, 8'h0F, t);
        repeat (2) @(negedge clk);
        check("inv5_rx_busy_dropped", nif.rx_busy[3], 0);
        drain(15);
        drive_pkt(1, 4'd8, 8'h96, t);
        expect_pkt(1, 4'd8, 8'h96, t + 3);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
